// File: rtl/demux_4_buf.sv
// 1-to-4 registered demultiplexer: one valid/ready input stream steered by i_sel
// into four independent one-entry output lanes, each with its own handshake.
module demux_4_buf #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_sel,
  input  logic [NBITS-1:0] i_data,
  output logic [3:0]       o_valid,
  input  logic [3:0]       i_ready,
  output logic [NBITS-1:0] o_data_a,
  output logic [NBITS-1:0] o_data_b,
  output logic [NBITS-1:0] o_data_c,
  output logic [NBITS-1:0] o_data_d,
  output logic [15:0]      o_count
);

  logic [3:0]       full_q;
  logic [NBITS-1:0] data_q [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  // A lane can take a new word when it is empty or is being drained this cycle.
  assign o_ready = ~full_q[i_sel] | i_ready[i_sel];
  assign accept  = i_valid & o_ready;
  assign drain   = full_q & i_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load = 4'b0000;
    if (accept) load[i_sel] = 1'b1;
  end

  // NOTE: the data registers are reset as well because the outputs must read zero after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      full_q <= 4'b0000;
      for (int n = 0; n < 4; n++) data_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        // NOTE: state uses non-blocking assignments so all lanes update from the same pre-edge values.
        if (load[n]) begin
          full_q[n] <= 1'b1;
          data_q[n] <= i_data;
        end else if (drain[n]) begin
          full_q[n] <= 1'b0;
        end
      end
    end
  end

  // Free-running accept counter; wraps silently at 16 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count <= 16'h0000;
    end else if (accept) begin
      o_count <= o_count + 16'h0001;
    end
  end

  assign o_valid  = full_q;
  assign o_data_a = data_q[0];
  assign o_data_b = data_q[1];
  assign o_data_c = data_q[2];
  assign o_data_d = data_q[3];

endmodule

// File: tb/tb_demux_4_buf.sv
// Self-checking bench for demux_4_buf: table-driven vectors plus hand-written
// back-pressure, asynchronous-reset and counter-wrap sequences.
module tb_demux_4_buf;

  localparam int NBITS = 32;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_sel;
  logic [NBITS-1:0] i_data;
  logic [3:0]       o_valid;
  logic [3:0]       i_ready;
  logic [NBITS-1:0] o_data_a, o_data_b, o_data_c, o_data_d;
  logic [15:0]      o_count;

  int checks = 0;
  int errors = 0;

  demux_4_buf #(.NBITS(NBITS)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sel    (i_sel),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data_a (o_data_a),
    .o_data_b (o_data_b),
    .o_data_c (o_data_c),
    .o_data_d (o_data_d),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_a, exp_b, exp_c, exp_d;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic [3:0] v, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c, input logic [31:0] d,
                             input logic [15:0] cnt);
    check({tag, " o_valid"}, 64'(o_valid), 64'(v));
    check({tag, " o_data_a"}, 64'(o_data_a), 64'(a));
    check({tag, " o_data_b"}, 64'(o_data_b), 64'(b));
    check({tag, " o_data_c"}, 64'(o_data_c), 64'(c));
    check({tag, " o_data_d"}, 64'(o_data_d), 64'(d));
    check({tag, " o_count"}, 64'(o_count), 64'(cnt));
  endtask

  initial begin
    //           valid sel   data           ready    rdy valid    a      b      c             d      count
    vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100, 32'h0,  32'h0,  32'hDEADBEEF, 32'h0,  16'd1};
    vecs[1]  = '{1'b0, 2'd2, 32'h0,        4'b0100, 1'b1, 4'b0000, 32'h0,  32'h0,  32'hDEADBEEF, 32'h0,  16'd1};
    vecs[2]  = '{1'b0, 2'd0, 32'h5A5A5A5A, 4'b0000, 1'b1, 4'b0000, 32'h0,  32'h0,  32'hDEADBEEF, 32'h0,  16'd1};
    vecs[3]  = '{1'b1, 2'd1, 32'h1,        4'b0010, 1'b1, 4'b0010, 32'h0,  32'h1,  32'hDEADBEEF, 32'h0,  16'd2};
    vecs[4]  = '{1'b1, 2'd1, 32'h2,        4'b0010, 1'b1, 4'b0010, 32'h0,  32'h2,  32'hDEADBEEF, 32'h0,  16'd3};
    vecs[5]  = '{1'b1, 2'd1, 32'h3,        4'b0010, 1'b1, 4'b0010, 32'h0,  32'h3,  32'hDEADBEEF, 32'h0,  16'd4};
    vecs[6]  = '{1'b1, 2'd1, 32'h4,        4'b0010, 1'b1, 4'b0010, 32'h0,  32'h4,  32'hDEADBEEF, 32'h0,  16'd5};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,        4'b0010, 1'b1, 4'b0000, 32'h0,  32'h4,  32'hDEADBEEF, 32'h0,  16'd5};
    vecs[8]  = '{1'b1, 2'd3, 32'hDD,       4'b0000, 1'b1, 4'b1000, 32'h0,  32'h4,  32'hDEADBEEF, 32'hDD, 16'd6};
    vecs[9]  = '{1'b1, 2'd0, 32'h11,       4'b0000, 1'b1, 4'b1001, 32'h11, 32'h4,  32'hDEADBEEF, 32'hDD, 16'd7};
    vecs[10] = '{1'b1, 2'd1, 32'h22,       4'b0000, 1'b1, 4'b1011, 32'h11, 32'h22, 32'hDEADBEEF, 32'hDD, 16'd8};
    vecs[11] = '{1'b1, 2'd3, 32'hEE,       4'b0000, 1'b0, 4'b1011, 32'h11, 32'h22, 32'hDEADBEEF, 32'hDD, 16'd8};
    vecs[12] = '{1'b1, 2'd3, 32'hEE,       4'b1000, 1'b1, 4'b1011, 32'h11, 32'h22, 32'hDEADBEEF, 32'hEE, 16'd9};
    vecs[13] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000, 32'h11, 32'h22, 32'hDEADBEEF, 32'hEE, 16'd9};

    // Power-on reset
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_sel   = 2'd0;
    i_data  = '0;
    i_ready = 4'b0000;
    #1;
    check("por o_ready", 64'(o_ready), 64'd1);
    check_lanes("por", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    tick();
    tick();
    i_reset = 1'b0;

    // Table-driven vectors: single transfer, streaming, lane independence, load+drain
    for (int i = 0; i < 14; i++) begin
      i_valid = vecs[i].valid;
      i_sel   = vecs[i].sel;
      i_data  = vecs[i].data;
      i_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d o_ready", i), 64'(o_ready), 64'(vecs[i].exp_ready));
      tick();
      check_lanes($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_a, vecs[i].exp_b,
                  vecs[i].exp_c, vecs[i].exp_d, vecs[i].exp_count);
    end

    // Back-pressure: lane a full and stalled, new word held three cycles
    i_valid = 1'b1; i_sel = 2'd0; i_data = 32'hA1; i_ready = 4'b0000;
    tick();
    check_lanes("bp load", 4'b0001, 32'hA1, 32'h22, 32'hDEADBEEF, 32'hEE, 16'd10);
    i_data = 32'hA2;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp stall%0d o_ready", c), 64'(o_ready), 64'd0);
      tick();
      check($sformatf("bp stall%0d o_data_a", c), 64'(o_data_a), 64'hA1);
      check($sformatf("bp stall%0d o_count", c), 64'(o_count), 64'd10);
    end
    i_ready = 4'b0001;
    #1;
    check("bp release o_ready", 64'(o_ready), 64'd1);
    tick();
    i_valid = 1'b0; i_ready = 4'b0000;
    check_lanes("bp release", 4'b0001, 32'hA2, 32'h22, 32'hDEADBEEF, 32'hEE, 16'd11);

    // Asynchronous reset mid-cycle with lane b full
    i_valid = 1'b1; i_sel = 2'd1; i_data = 32'hB5;
    tick();
    check("ar prefill o_valid", 64'(o_valid), 64'b0011);
    i_valid = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check("ar o_ready", 64'(o_ready), 64'd1);
    check_lanes("ar", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    i_valid = 1'b1; i_sel = 2'd2; i_data = 32'hC0FFEE;
    tick();
    check_lanes("ar held", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    i_valid = 1'b0;
    #2;
    i_reset = 1'b0;
    tick();

    // Counter wrap: stream into lane a with its consumer always ready
    i_valid = 1'b1; i_sel = 2'd0; i_ready = 4'b0001;
    for (int n = 1; n <= 65535; n++) begin
      i_data = 32'(n);
      tick();
    end
    check("wrap pre o_count", 64'(o_count), 64'hFFFF);
    check("wrap pre o_data_a", 64'(o_data_a), 64'd65535);
    i_data = 32'h10000;
    tick();
    check("wrap o_count", 64'(o_count), 64'h0000);
    check("wrap o_data_a", 64'(o_data_a), 64'h10000);
    i_valid = 1'b0;
    tick();
    check("wrap drain o_valid", 64'(o_valid), 64'd0);
    check("wrap drain o_count", 64'(o_count), 64'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
